// File: rtl/chunked_adder_mc.sv
// chunked_adder_mc: multi-cycle WIDTH-bit adder that ripples CHUNK bits per
// clock through one shared slice, with the carry registered between chunks.
// start/busy/done handshake; sum, c_out and overflow are held between results.
// Optional macro SUB_MODE_EN adds a 'sub' input (a - b as a + ~b + 1).
module chunked_adder_mc #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] sa, sb, ss;
  logic             sco, c_msb, last;

  // Inverting b with a forced carry-in of 1 turns the adder into a - b.
  logic             sub_sel;
`ifdef SUB_MODE_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Ripple slice on the current chunk; the MSB carry-in is recovered from the
  // sum bit, so no bit-level carry chain is needed for the overflow flag.
  always_comb begin
    sa         = a_r[idx*CHUNK +: CHUNK];
    sb         = b_r[idx*CHUNK +: CHUNK];
    {sco, ss}  = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, carry};
    c_msb      = ss[CHUNK-1] ^ sa[CHUNK-1] ^ sb[CHUNK-1];
    acc_nxt    = acc;
    acc_nxt[idx*CHUNK +: CHUNK] = ss;
    last       = (idx == LAST);
  end

  assign busy = (state == RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept start only in IDLE, leave RUN after the last chunk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, per-chunk accumulate, result load on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= sub_sel ? ~b : b;
          carry <= sub_sel ? 1'b1 : c_in;
          acc   <= '0;
          idx   <= '0;
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= sco;
          idx   <= idx + 1'b1;
          if (last) begin
            sum      <= acc_nxt;
            c_out    <= sco;
            overflow <= c_msb ^ sco;
            done     <= 1'b1;
            idx      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder_mc.sv
// Self-checking bench for chunked_adder_mc (WIDTH=32, CHUNK=4): directed vector
// table plus hand sequences for reset, handshake and mid-operation reset.
module tb_chunked_adder_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        c_in = 1'b0;
  logic        sub = 1'b0;
  logic        busy, done, c_out, overflow;
  logic [31:0] sum;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  chunked_adder_mc #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
`ifdef SUB_MODE_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        c_in, sub;
    logic [31:0] exp_sum;
    logic        exp_co, exp_ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one operation from a negedge; return cycles from accept edge to done.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic ic, input logic is, output int cyc);
    a = ia; b = ib; c_in = ic; sub = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!done && cyc < 8) begin
        total++;
        if (busy === 1'b1) pass_cnt++;
        else $display("FAIL busy_during_run: got %b expected 1 at cycle %0d", busy, cyc);
      end
    end
  endtask

  vec_t vecs[$];
  int   cyc;

  initial begin
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b0, 32'h0000000C, 1'b0, 1'b0});
`ifdef SUB_MODE_EN
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0});
    vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
`endif

    // Reset state
    #12;
    chk("rst_sum", sum, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub, cyc);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd8);
      chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_sum", i), sum, vecs[i].exp_sum);
      chk($sformatf("v%0d_cout", i), 32'(c_out), 32'(vecs[i].exp_co));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ov));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_sum_hold", i), sum, vecs[i].exp_sum);
    end

    // Asynchronous reset mid-cycle clears held result immediately
    sub = 1'b0;
    run_op(32'h00000100, 32'h00000023, 1'b0, 1'b0, cyc);
    chk("pre_arst_sum", sum, 32'h00000123);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("arst_sum", sum, 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Handshake: start held during RUN ignored; start in done cycle accepted
    a = 32'd1; b = 32'd2; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 32'h100; b = 32'h100;
    cyc = 0;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("hs_first_latency", 32'(cyc), 32'd8);
    chk("hs_first_sum", sum, 32'd3);
    a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    chk("hs_second_gap", 32'(cyc), 32'd9);
    chk("hs_second_sum", sum, 32'd7);

    // Reset mid-operation: no done, result discarded, then normal op
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_sum", sum, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc = 0;
    repeat (12) begin @(negedge clk); if (done) cyc++; end
    chk("midrst_no_done", 32'(cyc), 32'd0);
    run_op(32'd10, 32'd20, 1'b0, 1'b0, cyc);
    chk("post_rst_latency", 32'(cyc), 32'd8);
    chk("post_rst_sum", sum, 32'd30);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
